// File: rtl/pipe_pkg.sv
// Shared types for the decode-side operand stage: ID/EX payload, FSM state and register-zero constant.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } opst_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   rs;
    logic [XLEN-1:0]   rt;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [XLEN-1:0]   imm;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: r0, then EX, MEM, WB results, then register file data.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] Addr,
  input  logic [ADDR_W-1:0] ExRdAddr,
  input  logic              ExRegWrite,
  input  logic              ExMemRead,
  input  logic [WIDTH-1:0]  ExResult,
  input  logic [ADDR_W-1:0] MemRdAddr,
  input  logic              MemRegWrite,
  input  logic [WIDTH-1:0]  MemResult,
  input  logic [ADDR_W-1:0] WbRdAddr,
  input  logic              WbRegWrite,
  input  logic [WIDTH-1:0]  WbData,
  input  logic [WIDTH-1:0]  RfData,
  output logic [WIDTH-1:0]  Data,
  output logic              Hit
);

  logic is_zero;
  logic ex_match;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign is_zero  = (Addr == ADDR_W'(REG_ZERO));
  assign ex_match = ExRegWrite  && (ExRdAddr  == Addr);
  // A load in EX has no result yet, so it cannot be bypassed from there.
  assign ex_hit   = ex_match && !ExMemRead;
  assign mem_hit  = MemRegWrite && (MemRdAddr == Addr);
  assign wb_hit   = WbRegWrite  && (WbRdAddr  == Addr);

  // Any in-flight producer of this source, loads included.
  assign Hit = !is_zero && (ex_match || mem_hit || wb_hit);

  always_comb begin
    Data = RfData;
    if (is_zero)      Data = '0;
    else if (ex_hit)  Data = ExResult;
    else if (mem_hit) Data = MemResult;
    else if (wb_hit)  Data = WbData;
  end

endmodule

// File: rtl/operand_stage.sv
// Operand fetch with EX/MEM/WB bypass, load-use bubble insertion and the ID/EX pipeline register.
module operand_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int FWD_EN = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [ADDR_W-1:0] InRsAddr,
  input  logic              InRsUsed,
  input  logic [ADDR_W-1:0] InRtAddr,
  input  logic              InRtUsed,
  input  logic [ADDR_W-1:0] InRdAddr,
  input  logic              InRegWrite,
  input  logic              InMemRead,
  input  logic [WIDTH-1:0]  InImm,
  output logic [ADDR_W-1:0] RsAddr,
  output logic [ADDR_W-1:0] RtAddr,
  input  logic [WIDTH-1:0]  RsData,
  input  logic [WIDTH-1:0]  RtData,
  input  logic [ADDR_W-1:0] ExRdAddr,
  input  logic              ExRegWrite,
  input  logic              ExMemRead,
  input  logic [WIDTH-1:0]  ExResult,
  input  logic [ADDR_W-1:0] MemRdAddr,
  input  logic              MemRegWrite,
  input  logic [WIDTH-1:0]  MemResult,
  input  logic [ADDR_W-1:0] WbRdAddr,
  input  logic              WbRegWrite,
  input  logic [WIDTH-1:0]  WbData,
  output logic              IdStall,
  output logic              OutValid,
  output logic [WIDTH-1:0]  OutRsData,
  output logic [WIDTH-1:0]  OutRtData,
  output logic [ADDR_W-1:0] OutRdAddr,
  output logic              OutRegWrite,
  output logic              OutMemRead,
  output logic [WIDTH-1:0]  OutImm,
  output logic [31:0]       StallCount
);

  localparam bit FWD = (FWD_EN != 0);

  opst_t             state_p1;
  logic              vld_p1;
  logic [WIDTH-1:0]  rs_data_p1;
  logic [WIDTH-1:0]  rt_data_p1;
  logic [ADDR_W-1:0] rd_addr_p1;
  logic              regwrite_p1;
  logic              memread_p1;
  logic [WIDTH-1:0]  imm_p1;
  logic [31:0]       stall_count;

  logic [WIDTH-1:0]  rs_fwd_p0;
  logic [WIDTH-1:0]  rt_fwd_p0;
  logic              rs_hit_p0;
  logic              rt_hit_p0;
  logic [WIDTH-1:0]  rs_sel_p0;
  logic [WIDTH-1:0]  rt_sel_p0;
  logic              load_hz_p0;
  logic              nofwd_hz_p0;
  logic              hazard_p0;

  assign RsAddr = InRsAddr;
  assign RtAddr = InRtAddr;

  fwd_mux #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rs_mux (
    .Addr(InRsAddr), .ExRdAddr(ExRdAddr), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExResult(ExResult), .MemRdAddr(MemRdAddr), .MemRegWrite(MemRegWrite), .MemResult(MemResult),
    .WbRdAddr(WbRdAddr), .WbRegWrite(WbRegWrite), .WbData(WbData), .RfData(RsData),
    .Data(rs_fwd_p0), .Hit(rs_hit_p0)
  );

  fwd_mux #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rt_mux (
    .Addr(InRtAddr), .ExRdAddr(ExRdAddr), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExResult(ExResult), .MemRdAddr(MemRdAddr), .MemRegWrite(MemRegWrite), .MemResult(MemResult),
    .WbRdAddr(WbRdAddr), .WbRegWrite(WbRegWrite), .WbData(WbData), .RfData(RtData),
    .Data(rt_fwd_p0), .Hit(rt_hit_p0)
  );

  // Without bypassing only r0 is special; everything else comes from the register file.
  assign rs_sel_p0 = FWD ? rs_fwd_p0 : ((InRsAddr == ADDR_W'(REG_ZERO)) ? '0 : RsData);
  assign rt_sel_p0 = FWD ? rt_fwd_p0 : ((InRtAddr == ADDR_W'(REG_ZERO)) ? '0 : RtData);

  assign load_hz_p0 = InValid && ExMemRead && ExRegWrite && (ExRdAddr != ADDR_W'(REG_ZERO)) &&
                      ((InRsUsed && (InRsAddr == ExRdAddr)) ||
                       (InRtUsed && (InRtAddr == ExRdAddr)));

  assign nofwd_hz_p0 = !FWD && InValid && ((InRsUsed && rs_hit_p0) || (InRtUsed && rt_hit_p0));

  // In BUBBLE the EX slot holds our own bubble, so only the no-bypass hazard can recur.
  assign hazard_p0 = ((state_p1 == RUN) && load_hz_p0) || nofwd_hz_p0;

  assign IdStall = !Stall && !Flush && hazard_p0;

  // ID -> ID/EX register boundary
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_p1    <= RUN;
      vld_p1      <= 1'b0;
      rs_data_p1  <= '0;
      rt_data_p1  <= '0;
      rd_addr_p1  <= '0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      imm_p1      <= '0;
      stall_count <= '0;
    end else if (!Stall) begin
      rs_data_p1 <= rs_sel_p0;
      rt_data_p1 <= rt_sel_p0;
      rd_addr_p1 <= InRdAddr;
      imm_p1     <= InImm;
      if (Flush) begin
        state_p1    <= RUN;
        vld_p1      <= 1'b0;
        regwrite_p1 <= 1'b0;
        memread_p1  <= 1'b0;
      end else if (hazard_p0) begin
        state_p1    <= BUBBLE;
        vld_p1      <= 1'b0;
        regwrite_p1 <= 1'b0;
        memread_p1  <= 1'b0;
        stall_count <= stall_count + 32'd1;
      end else begin
        state_p1    <= RUN;
        vld_p1      <= InValid;
        regwrite_p1 <= InRegWrite;
        memread_p1  <= InMemRead;
      end
    end
  end

  assign OutValid    = vld_p1;
  assign OutRsData   = rs_data_p1;
  assign OutRtData   = rt_data_p1;
  assign OutRdAddr   = rd_addr_p1;
  assign OutRegWrite = regwrite_p1;
  assign OutMemRead  = memread_p1;
  assign OutImm      = imm_p1;
  assign StallCount  = stall_count;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: bypass priority, load-use bubble, flush, stall hold, counter wrap.
module tb_operand_stage;

  logic        Clock;
  logic        Reset;
  logic        Stall, Flush, InValid;
  logic [4:0]  InRsAddr, InRtAddr, InRdAddr;
  logic        InRsUsed, InRtUsed, InRegWrite, InMemRead;
  logic [31:0] InImm;
  logic [4:0]  RsAddr, RtAddr;
  logic [31:0] RsData, RtData;
  logic [4:0]  ExRdAddr, MemRdAddr, WbRdAddr;
  logic        ExRegWrite, ExMemRead, MemRegWrite, WbRegWrite;
  logic [31:0] ExResult, MemResult, WbData;
  logic        IdStall, OutValid, OutRegWrite, OutMemRead;
  logic [31:0] OutRsData, OutRtData, OutImm, StallCount;
  logic [4:0]  OutRdAddr;

  int errors = 0;
  int checks = 0;

  operand_stage #(.WIDTH(32), .ADDR_W(5), .FWD_EN(1)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .InRsAddr(InRsAddr), .InRsUsed(InRsUsed), .InRtAddr(InRtAddr), .InRtUsed(InRtUsed),
    .InRdAddr(InRdAddr), .InRegWrite(InRegWrite), .InMemRead(InMemRead), .InImm(InImm),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(RsData), .RtData(RtData),
    .ExRdAddr(ExRdAddr), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExResult(ExResult),
    .MemRdAddr(MemRdAddr), .MemRegWrite(MemRegWrite), .MemResult(MemResult),
    .WbRdAddr(WbRdAddr), .WbRegWrite(WbRegWrite), .WbData(WbData),
    .IdStall(IdStall), .OutValid(OutValid), .OutRsData(OutRsData), .OutRtData(OutRtData),
    .OutRdAddr(OutRdAddr), .OutRegWrite(OutRegWrite), .OutMemRead(OutMemRead),
    .OutImm(OutImm), .StallCount(StallCount)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    Stall = 0; Flush = 0; InValid = 0;
    InRsAddr = 0; InRtAddr = 0; InRdAddr = 0;
    InRsUsed = 0; InRtUsed = 0; InRegWrite = 0; InMemRead = 0; InImm = 0;
    RsData = 0; RtData = 0;
    ExRdAddr = 0; ExRegWrite = 0; ExMemRead = 0; ExResult = 0;
    MemRdAddr = 0; MemRegWrite = 0; MemResult = 0;
    WbRdAddr = 0; WbRegWrite = 0; WbData = 0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_use_setup();
    clear_in();
    InValid = 1; InRtAddr = 4; InRtUsed = 1; InRdAddr = 6; InRegWrite = 1;
    RtData = 32'h77;
    ExRdAddr = 4; ExRegWrite = 1; ExMemRead = 1; ExResult = 32'hBAD0;
  endtask

  task automatic load_in_mem();
    ExRegWrite = 0; ExMemRead = 0; ExRdAddr = 0;
    MemRdAddr = 4; MemRegWrite = 1; MemResult = 32'hDEAD;
  endtask

  initial begin
    clear_in();
    Reset = 1;
    #12;
    chk("rst_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_count", StallCount, 32'd0);
    Reset = 0;

    // plain load through register file
    InValid = 1; InRsAddr = 1; InRsUsed = 1; RsData = 32'h1234;
    InRdAddr = 9; InRegWrite = 1; InImm = 32'hFFFF_FFF0;
    #1 chk("rs_addr_comb", {27'd0, RsAddr}, 32'd1);
    step();
    chk("plain_valid", {31'd0, OutValid}, 32'd1);
    chk("plain_rs", OutRsData, 32'h1234);
    chk("plain_rd", {27'd0, OutRdAddr}, 32'd9);
    chk("plain_imm", OutImm, 32'hFFFF_FFF0);

    // asynchronous reset in mid-cycle
    #2 Reset = 1;
    #1;
    chk("amid_valid", {31'd0, OutValid}, 32'd0);
    chk("amid_rs", OutRsData, 32'd0);
    chk("amid_rd", {27'd0, OutRdAddr}, 32'd0);
    chk("amid_imm", OutImm, 32'd0);
    chk("amid_rw", {31'd0, OutRegWrite}, 32'd0);
    #1 Reset = 0;

    // EX bypass
    clear_in();
    InValid = 1; InRsAddr = 3; InRsUsed = 1; RsData = 32'h5;
    ExRdAddr = 3; ExRegWrite = 1; ExResult = 32'hAAAA_0001;
    step();
    chk("ex_bypass", OutRsData, 32'hAAAA_0001);

    // EX beats MEM
    clear_in();
    InValid = 1; InRtAddr = 7; InRtUsed = 1; RtData = 32'h99;
    ExRdAddr = 7; ExRegWrite = 1; ExResult = 32'h11;
    MemRdAddr = 7; MemRegWrite = 1; MemResult = 32'h22;
    step();
    chk("ex_over_mem", OutRtData, 32'h11);

    // MEM beats WB
    ExRegWrite = 0;
    WbRdAddr = 7; WbRegWrite = 1; WbData = 32'h33;
    step();
    chk("mem_over_wb", OutRtData, 32'h22);

    // WB only
    MemRegWrite = 0; RtData = 32'h0;
    step();
    chk("wb_only", OutRtData, 32'h33);

    // r0 ignores all bypasses
    clear_in();
    InValid = 1; InRsAddr = 0; InRtAddr = 0; InRsUsed = 1; InRtUsed = 1;
    RsData = 32'hFFFF; RtData = 32'hEEEE;
    ExRdAddr = 0; ExRegWrite = 1; ExResult = 32'h1;
    MemRdAddr = 0; MemRegWrite = 1; MemResult = 32'h2;
    WbRdAddr = 0; WbRegWrite = 1; WbData = 32'h3;
    step();
    chk("r0_rs", OutRsData, 32'd0);
    chk("r0_rt", OutRtData, 32'd0);

    // load in EX but rt not a true source: no stall
    load_use_setup();
    InRtUsed = 0;
    #1 chk("unused_idstall", {31'd0, IdStall}, 32'd0);
    step();
    chk("unused_valid", {31'd0, OutValid}, 32'd1);
    chk("unused_rt", OutRtData, 32'h77);
    chk("unused_count", StallCount, 32'd0);

    // load-use bubble then MEM forward
    load_use_setup();
    #1 chk("lu_idstall", {31'd0, IdStall}, 32'd1);
    step();
    chk("lu_valid", {31'd0, OutValid}, 32'd0);
    chk("lu_rw", {31'd0, OutRegWrite}, 32'd0);
    chk("lu_count", StallCount, 32'd1);
    load_in_mem();
    #1 chk("lu_idstall2", {31'd0, IdStall}, 32'd0);
    step();
    chk("lu_resolve_rt", OutRtData, 32'hDEAD);
    chk("lu_resolve_valid", {31'd0, OutValid}, 32'd1);
    chk("lu_resolve_count", StallCount, 32'd1);

    // flush during hazard
    load_use_setup();
    Flush = 1;
    #1 chk("fl_idstall", {31'd0, IdStall}, 32'd0);
    step();
    chk("fl_valid", {31'd0, OutValid}, 32'd0);
    chk("fl_count", StallCount, 32'd1);
    Flush = 0;
    #1 chk("fl_run_idstall", {31'd0, IdStall}, 32'd1);
    step();
    chk("fl_run_count", StallCount, 32'd2);
    load_in_mem();
    step();
    chk("fl_resolve_valid", {31'd0, OutValid}, 32'd1);

    // stall hold
    clear_in();
    InValid = 1; InRsAddr = 2; InRsUsed = 1; RsData = 32'h100; InRdAddr = 5; InRegWrite = 1;
    step();
    chk("pre_stall_rs", OutRsData, 32'h100);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) load_use_setup();
      else begin
        InRsAddr = 5'(i + 10); RsData = 32'hC0 + 32'(i); InValid = 1'(i);
      end
      Stall = 1;
      #1 chk("hold_idstall", {31'd0, IdStall}, 32'd0);
      step();
      chk("hold_rs", OutRsData, 32'h100);
      chk("hold_valid", {31'd0, OutValid}, 32'd1);
      chk("hold_rd", {27'd0, OutRdAddr}, 32'd5);
      chk("hold_count", StallCount, 32'd2);
    end
    clear_in();
    InValid = 1; InRsAddr = 2; InRsUsed = 1; RsData = 32'h200; InRdAddr = 8;
    step();
    chk("release_rs", OutRsData, 32'h200);
    chk("release_rd", {27'd0, OutRdAddr}, 32'd8);

    // counter wrap
    @(negedge Clock);
    force dut.stall_count = 32'hFFFF_FFFF;
    #1 release dut.stall_count;
    chk("wrap_preset", StallCount, 32'hFFFF_FFFF);
    load_use_setup();
    step();
    chk("wrap_count", StallCount, 32'd0);
    chk("wrap_valid", {31'd0, OutValid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
